// File: rtl/otter_pkg.sv
// Shared types and constants for the OTTER fetch front end.
package otter_pkg;

    localparam logic [31:0] OTTER_RESET_PC = 32'h0000_0000;

    // One queued fetch: instruction word plus the PC it came from.
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } fq_entry_t;

    // Instruction PCs are always word aligned; low bits are discarded.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/otter_fetch_queue_fifo.sv
// fq_fifo: DEPTH-entry circular buffer of fetch entries with push, pop and
// flush. Flush wins over push/pop. Pop when empty and push when full (without
// a simultaneous pop) are ignored.
module fq_fifo
    import otter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fq_entry_t                wdata,
    output fq_entry_t                head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    fq_entry_t       mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/otter_fetch_queue.sv
// otter_fetch_queue: fetch PC, credit-based issue to instruction memory port 1,
// and a small queue presenting {ir, pc} to decode over valid/ready.
// Optional feature macro: OTTER_FQ_BYPASS_EN -- an accepted response drives
// decode combinationally when the queue is empty.
module otter_fetch_queue
    import otter_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = OTTER_RESET_PC
) (
    input  logic                     CLK,
    input  logic                     RST,
    output logic                     IMEM_RDEN,
    output logic [13:0]              IMEM_ADDR,
    input  logic [31:0]              IMEM_DOUT,
    input  logic                     REDIRECT,
    input  logic [31:0]              REDIRECT_PC,
    output logic                     DE_VALID,
    input  logic                     DE_READY,
    output logic [31:0]              DE_IR,
    output logic [31:0]              DE_PC,
    output logic [31:0]              DE_PC_INC,
    output logic [$clog2(DEPTH):0]   FQ_COUNT
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   pending_pc;
    logic          pending;
    logic [31:0]   issue_pc;
    logic          issue;
    logic [CW:0]   inflight;
    logic          accept;
    logic          bypass;
    fq_entry_t     resp;
    fq_entry_t     fq_head;
    fq_entry_t     de_entry;
    logic [CW-1:0] fq_count;
    logic          fq_empty;
    logic          fq_full;
    logic          fq_push;
    logic          fq_pop;

    // Queued entries plus the read in flight must leave room for one more.
    assign inflight  = {1'b0, fq_count} + {{CW{1'b0}}, pending};
    assign issue_pc  = REDIRECT ? word_align(REDIRECT_PC) : fetch_pc;
    // RST gating keeps the strobe low while reset is held.
    assign issue     = RST && (REDIRECT || (inflight < (CW + 1)'(DEPTH)));
    assign IMEM_RDEN = issue;
    assign IMEM_ADDR = issue_pc[15:2];

    // A response returning in a redirect cycle is wrong-path and dropped.
    assign accept = pending && !REDIRECT;
    assign resp   = '{ir: IMEM_DOUT, pc: pending_pc};

    // Decode-side mux: queue head, or the live response when bypass applies.
    always_comb begin
        bypass   = 1'b0;
        de_entry = fq_head;
`ifdef OTTER_FQ_BYPASS_EN
        bypass = accept && fq_empty;
        if (fq_empty) de_entry = resp;
`endif
    end

    assign DE_VALID  = !REDIRECT && (!fq_empty || bypass);
    assign DE_IR     = de_entry.ir;
    assign DE_PC     = de_entry.pc;
    assign DE_PC_INC = de_entry.pc + 32'd4;
    assign FQ_COUNT  = fq_count;

    // A bypassed response consumed this cycle never enters the queue.
    assign fq_push = accept && !(bypass && DE_READY);
    assign fq_pop  = !REDIRECT && !fq_empty && DE_READY;

    // Fetch PC and in-flight read tracking.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fetch_pc   <= RESET_PC;
            pending_pc <= '0;
            pending    <= 1'b0;
        end else if (issue) begin
            pending_pc <= issue_pc;
            fetch_pc   <= issue_pc + 32'd4;
            pending    <= 1'b1;
        end else begin
            pending    <= 1'b0;
        end
    end

    fq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .push  (fq_push),
        .pop   (fq_pop),
        .flush (REDIRECT),
        .wdata (resp),
        .head  (fq_head),
        .count (fq_count),
        .empty (fq_empty),
        .full  (fq_full)
    );

endmodule
